// File: rtl/bf16_div_pkg.sv
// Shared FPU package for the bfloat16 divider.
// Holds the bfloat16 field widths, exponent bias, special bit patterns,
// quotient width, FSM state type and the restoring-divider step helper.
package bf16_div_pkg;
    localparam int EXP_W = 8;
    localparam int MAN_W = 7;
    localparam int BIAS  = 127;
    localparam int Q_W   = 10;

    localparam logic [15:0] CANON_NAN = 16'h7FC0;
    localparam logic [15:0] POS_INF   = 16'h7F80;

    typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;

    // One restoring step. Returns {quotient bit, next partial remainder}.
    // The partial remainder stays below 2*d, so it fits comfortably in 10 bits.
    function automatic logic [10:0] div_step(input logic [9:0] rem, input logic [7:0] d);
        logic       ge;
        logic [9:0] t;
        ge = (rem >= {2'b00, d});
        t  = ge ? (rem - {2'b00, d}) : rem;
        return {ge, t[8:0], 1'b0};
    endfunction
endpackage

// File: rtl/bf16_div_fp_class.sv
// FP_Class: classifies one bfloat16 operand.
// Ports: x (operand), is_nan, is_inf, is_zero (subnormals count as zero).
module FP_Class
    import bf16_div_pkg::*;
(
    input  logic [15:0] x,
    output logic        is_nan,
    output logic        is_inf,
    output logic        is_zero
);
    logic exp_max;
    logic man_nz;

    assign exp_max = (x[14:7] == 8'hFF);
    assign man_nz  = (x[6:0] != 7'd0);
    assign is_nan  = exp_max & man_nz;
    assign is_inf  = exp_max & ~man_nz;
    assign is_zero = (x[14:7] == 8'h00);
endmodule

// File: rtl/bf16_div.sv
// bf16_div: iterative bfloat16 divider, result = a / b, round-to-nearest-even.
// Ports: clk_i, rst_i (sync, active-high); in_valid_i/in_ready_o with a_i, b_i;
//        out_valid_o/out_ready_i with result_o and div_by_zero_o.
// Config macro: BF16_DIV_RADIX4_EN retires two quotient bits per DIV cycle.
module bf16_div
    import bf16_div_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [15:0] result_o,
    output logic        div_by_zero_o
);
    state_t      state;
    logic [3:0]  cnt;
    logic [9:0]  rem;
    logic [9:0]  q;
    logic [7:0]  sb;
    logic        sgn;
    logic [9:0]  ediff;

    logic a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;

    FP_Class u_cls_a (.x(a_i), .is_nan(a_nan), .is_inf(a_inf), .is_zero(a_zero));
    FP_Class u_cls_b (.x(b_i), .is_nan(b_nan), .is_inf(b_inf), .is_zero(b_zero));

    // Special-case decode straight from the incoming operands.
    logic        in_sgn;
    logic        sp;
    logic [15:0] sp_res;
    logic        sp_dbz;

    assign in_sgn = a_i[15] ^ b_i[15];

    always_comb begin
        sp     = 1'b1;
        sp_res = CANON_NAN;
        sp_dbz = 1'b0;
        if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf)) begin
            sp_res = CANON_NAN;
        end else if (a_inf) begin
            sp_res = POS_INF | {in_sgn, 15'd0};
        end else if (b_inf) begin
            sp_res = {in_sgn, 15'd0};
        end else if (b_zero) begin
            sp_res = POS_INF | {in_sgn, 15'd0};
            sp_dbz = 1'b1;
        end else if (a_zero) begin
            sp_res = {in_sgn, 15'd0};
        end else begin
            sp = 1'b0;
        end
    end

    // Divider iteration.
    logic [10:0] s1;
    logic [9:0]  nxt_q;
    logic [9:0]  nxt_rem;
    logic        last;

    assign s1 = div_step(rem, sb);
`ifdef BF16_DIV_RADIX4_EN
    logic [10:0] s2;
    assign s2      = div_step(s1[9:0], sb);
    assign nxt_q   = {q[7:0], s1[10], s2[10]};
    assign nxt_rem = s2[9:0];
    assign last    = (cnt == 4'd4);
`else
    assign nxt_q   = {q[8:0], s1[10]};
    assign nxt_rem = s1[9:0];
    assign last    = (cnt == 4'd9);
`endif

    // Normalize, round and pack. Q[9] tells whether sa >= sb.
    logic [6:0]  man;
    logic        grd;
    logic        stk;
    logic [9:0]  e;
    logic [7:0]  rnd;
    logic [9:0]  e_f;
    logic [6:0]  man_f;
    logic [15:0] packed_res;

    always_comb begin
        man   = q[9] ? q[8:2] : q[7:1];
        grd   = q[9] ? q[1] : q[0];
        stk   = (q[9] & q[0]) | (rem != 10'd0);
        e     = ediff + (q[9] ? 10'd127 : 10'd126);
        rnd   = {1'b0, man} + {7'd0, grd & (stk | man[0])};
        e_f   = rnd[7] ? e + 10'd1 : e;
        man_f = rnd[7] ? 7'd0 : rnd[6:0];
        if ($signed(e_f) >= $signed(10'd255))
            packed_res = POS_INF | {sgn, 15'd0};
        else if ($signed(e_f) <= $signed(10'd0))
            packed_res = {sgn, 15'd0};
        else
            packed_res = {sgn, e_f[7:0], man_f};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            in_ready_o    <= 1'b1;
            out_valid_o   <= 1'b0;
            result_o      <= 16'h0000;
            div_by_zero_o <= 1'b0;
            cnt           <= 4'd0;
            rem           <= 10'd0;
            q             <= 10'd0;
            sb            <= 8'd0;
            sgn           <= 1'b0;
            ediff         <= 10'd0;
        end else begin
            case (state)
                IDLE: if (in_valid_i) begin
                    in_ready_o <= 1'b0;
                    sgn        <= in_sgn;
                    if (sp) begin
                        result_o      <= sp_res;
                        div_by_zero_o <= sp_dbz;
                        out_valid_o   <= 1'b1;
                        state         <= DONE;
                    end else begin
                        rem   <= {3'b001, a_i[6:0]};
                        sb    <= {1'b1, b_i[6:0]};
                        q     <= 10'd0;
                        cnt   <= 4'd0;
                        ediff <= {2'b00, a_i[14:7]} - {2'b00, b_i[14:7]};
                        state <= DIV;
                    end
                end
                DIV: begin
                    q   <= nxt_q;
                    rem <= nxt_rem;
                    cnt <= cnt + 4'd1;
                    if (last) begin
                        cnt   <= 4'd0;
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    result_o      <= packed_res;
                    div_by_zero_o <= 1'b0;
                    out_valid_o   <= 1'b1;
                    state         <= DONE;
                end
                DONE: if (out_ready_i) begin
                    out_valid_o <= 1'b0;
                    in_ready_o  <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/bf16_div.md
# bf16_div

Iterative bfloat16 divider, the inverse-operation companion to the FPU's combinational bfloat16 multiplier. It computes result = a / b with round-to-nearest-even and uses a valid/ready handshake on both input and output. A restoring divider produces one quotient bit per cycle, so the block takes one operation at a time. It sits in the FPU beside the multiplier and is driven by the same issue logic.

## Interface
- CANON_NAN, 16'h7FC0, bit pattern returned for every NaN-producing case.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- in_valid_i  in  1  operands a_i/b_i are valid.
- in_ready_o  out  1  block can accept an operation; high only in IDLE.
- a_i  in  16  dividend, bfloat16 {sign, exp[7:0], man[6:0]}.
- b_i  in  16  divisor, bfloat16.
- out_valid_o  out  1  result_o and div_by_zero_o are valid; held until accepted.
- out_ready_i  in  1  consumer accepts the result.
- result_o  out  16  quotient, bfloat16.
- div_by_zero_o  out  1  finite nonzero a divided by zero; qualified by out_valid_o.

## Operation
- Classification of each operand, in priority order: NaN (exp=FF, man≠0); Inf (exp=FF, man=0); zero (exp=00, any man; subnormals flush to zero); otherwise normal.
- Result sign = a[15]^b[15] for all non-NaN results.
- Special cases, in priority order:
  - Either operand NaN, 0/0, or Inf/Inf → CANON_NAN.
  - Inf/x → ±Inf.
  - x/Inf → ±0.
  - finite nonzero / 0 → ±Inf with div_by_zero_o=1.
  - 0/x → ±0.
  - div_by_zero_o=0 in every other case.
- Normal path:
  - sa={1,a[6:0]}, sb={1,b[6:0]}.
  - The restoring divider forms Q = floor(sa·2^9 / sb) (10 bits, range 256..1023) and remainder R.
  - If Q[9]=1: man=Q[8:2], guard=Q[1], sticky=Q[0]|(R≠0), e=ea−eb+127.
  - Otherwise: man=Q[7:1], guard=Q[0], sticky=(R≠0), e=ea−eb+126.
  - e is evaluated as a 10-bit signed value.
  - Rounding: increment man if guard & (sticky | man[0]). If man carries out, man=0 and e=e+1.
  - e ≥ 255 → ±Inf (0x7F80 | sign). e ≤ 0 → ±0 (flush). Otherwise {sign, e[7:0], man}.
- FSM states: IDLE, DIV, ROUND, DONE.
  - IDLE: on in_valid_i & in_ready_o, latch the operands. A special case goes to DONE with its result already formed; otherwise go to DIV with the iteration counter at 0.
  - DIV: one quotient bit per cycle. Counter runs 0..9; after the 10th bit, go to ROUND.
  - ROUND: normalize, round and pack; go to DONE.
  - DONE: out_valid_o=1. On out_ready_i, go to IDLE.
- Inputs while not in IDLE are ignored, because in_ready_o=0.

## Timing
- Reset values: state=IDLE, in_ready_o=1, out_valid_o=0, result_o=16'h0000, div_by_zero_o=0, counter=0.
- Cycle 0 is the acceptance edge.
- Normal path: out_valid_o rises at cycle 12 (10 DIV cycles plus 1 ROUND cycle).
- Special case: out_valid_o rises at cycle 1.
- result_o and div_by_zero_o are stable from out_valid_o rising until the handshake completes.
- in_ready_o returns high in the cycle after the out handshake. There is no same-cycle accept in DONE, so the throughput is one operation per 13 cycles on the normal path.
- Reset asserted mid-operation: the next cycle is IDLE with reset values; the in-flight result is discarded and never presented.
- in_ready_o and out_valid_o are registered (decoded from state), with no combinational path from any input.

## Configuration
- BF16_DIV_RADIX4_EN defined: the divider retires 2 quotient bits per cycle. DIV takes 5 cycles and normal-path out_valid_o rises at cycle 7. Results are bit-identical.
- Not defined: radix-2, with DIV taking 10 cycles and out_valid_o at cycle 12.

## Structure
- Shared FPU package holds:
  - the bfloat16 field widths;
  - the exponent bias 127;
  - CANON_NAN, the +Inf pattern 16'h7F80, and the quotient width 10;
  - the state enum typedef.
- Sub-module: reuse FP_Class for operand classification, one instance per operand.
- Divider datapath and rounding stay inline in bf16_div.

## Test plan
- 0x40C0 / 0x4000 (6/2), out_ready_i held high → result_o=0x4040 and out_valid_o rises exactly at cycle 12.
- 0x3F80 / 0x4040 (1/3) → 0x3EAB, exercising round-up with guard=1 and sticky=1. Also 0x3F80 / 0x3F80 → 0x3F80.
- 0xBF80 / 0x0000 → 0xFF80 with div_by_zero_o=1 at cycle 1.
- 0x0000 / 0x0000 → 0x7FC0, and 0x7F80 / 0x7F80 → 0x7FC0, both with div_by_zero_o=0.
- Overflow and underflow saturation:
  - 0x7F00 / 0x3E80 → 0x7F80.
  - 0x0080 / 0x4000 → 0x0000.
- Handshake and reset:
  - Hold out_ready_i low for 5 cycles in DONE → result_o stable and in_ready_o=0 throughout.
  - Assert in_valid_i while busy → the operation is ignored.
  - Pulse rst_i at cycle 5 of DIV → IDLE next cycle, no out_valid_o, and a fresh operation completes correctly.
